// File: rtl/hazard_unit_param_pkg.sv
// Shared definitions for the hazard/forwarding controller: the "operand not used"
// Tuse code, pipeline-register indices and the exception-flush state encoding.
package hazard_unit_param_pkg;

   // All-ones Tuse means the operand is never read; sliced down to the Tuse width at use.
   localparam logic [31:0] T_NOUSE = 32'hFFFF_FFFF;

   // Pipeline-register indices for the en_stage/clr_stage vectors.
   // Register 0 sits between fetch and decode, register 1 between decode and EX.
   localparam int unsigned REG_IFID = 0;
   localparam int unsigned REG_IDEX = 1;

   // Exception-flush controller states.
   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } exc_state_e;

endpackage

// File: rtl/hazard_unit_param_fwd_sel.sv
// Per-operand forwarding and data-hazard evaluation. The nearest matching producer
// decides the operand: it forwards if its result is ready, otherwise it shadows
// every older stage and the GRF value is passed (the stall logic holds decode).
module hazard_fwd_sel
   import hazard_unit_param_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RA_W     = 5,
   parameter int T_W      = 2,
   parameter int NUM_PROD = 3
) (
   input  logic [RA_W-1:0]          src_addr,
   input  logic [T_W-1:0]           src_tuse,
   input  logic [XLEN-1:0]          src_grf,
   input  logic [NUM_PROD*RA_W-1:0] p_addr,
   input  logic [NUM_PROD*T_W-1:0]  p_tnew,
   input  logic [NUM_PROD*XLEN-1:0] p_data,
   input  logic [NUM_PROD-1:0]      p_valid,
   output logic [XLEN-1:0]          fwd_data,
   output logic                     data_stall
);

   localparam logic [T_W-1:0] NOUSE = T_NOUSE[T_W-1:0];

   // Walk from the oldest producer to the nearest so the nearest match is applied last
   // and wins; any match whose result arrives too late for this operand raises a stall.
   always_comb begin
      fwd_data   = src_grf;
      data_stall = 1'b0;
      for (int i = NUM_PROD - 1; i >= 0; i--) begin
         if (p_valid[i] && (src_addr != '0) && (p_addr[i*RA_W +: RA_W] == src_addr)) begin
            if (p_tnew[i*T_W +: T_W] == '0) begin
               fwd_data = p_data[i*XLEN +: XLEN];
            end else begin
               fwd_data = src_grf;
            end
            if ((src_tuse != NOUSE) && (src_tuse < p_tnew[i*T_W +: T_W])) begin
               data_stall = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_unit_param.sv
// Hazard/forwarding controller for the N-stage pipeline: resolves decode operands,
// combines data, MDU and eret stalls, runs the exception-flush sequencer and keeps a
// saturating count of stall cycles. Drives pipeline-register enables and clears.
module hazard_unit_param
   import hazard_unit_param_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int RA_W     = 5,
   parameter int T_W      = 2,
   parameter int NUM_PROD = 3,
   parameter int MUL_LAT  = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [RA_W-1:0]          d_rs_addr,
   input  logic [RA_W-1:0]          d_rt_addr,
   input  logic [T_W-1:0]           d_rs_tuse,
   input  logic [T_W-1:0]           d_rt_tuse,
   input  logic [XLEN-1:0]          d_rs_grf,
   input  logic [XLEN-1:0]          d_rt_grf,
   input  logic                     d_is_mdu,
   input  logic                     d_is_eret,
   input  logic [NUM_PROD*RA_W-1:0] p_addr,
   input  logic [NUM_PROD*T_W-1:0]  p_tnew,
   input  logic [NUM_PROD*XLEN-1:0] p_data,
   input  logic [NUM_PROD-1:0]      p_valid,
   input  logic                     ex_mtc0_epc,
   input  logic                     mdu_start,
   input  logic                     mdu_is_div,
   input  logic                     exc_req,
   output logic [XLEN-1:0]          d_rs_fwd,
   output logic [XLEN-1:0]          d_rt_fwd,
   output logic                     stall,
   output logic                     en_pc,
   output logic [NUM_PROD:0]        en_stage,
   output logic [NUM_PROD:0]        clr_stage,
   output logic                     mdu_busy,
   output logic [31:0]              stall_cnt
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   logic             rs_stall;
   logic             rt_stall;
   logic             mdu_stall;
   logic             eret_stall;
   logic             raw_stall;
   logic             flush;

   exc_state_e       state_q;
   exc_state_e       state_d;
   logic [CNT_W-1:0] mdu_cnt_q;
   logic [CNT_W-1:0] mdu_cnt_d;
   logic [31:0]      stall_cnt_q;
   logic [31:0]      stall_cnt_d;

   hazard_fwd_sel #(
      .XLEN     (XLEN),
      .RA_W     (RA_W),
      .T_W      (T_W),
      .NUM_PROD (NUM_PROD)
   ) u_rs_sel (
      .src_addr   (d_rs_addr),
      .src_tuse   (d_rs_tuse),
      .src_grf    (d_rs_grf),
      .p_addr     (p_addr),
      .p_tnew     (p_tnew),
      .p_data     (p_data),
      .p_valid    (p_valid),
      .fwd_data   (d_rs_fwd),
      .data_stall (rs_stall)
   );

   hazard_fwd_sel #(
      .XLEN     (XLEN),
      .RA_W     (RA_W),
      .T_W      (T_W),
      .NUM_PROD (NUM_PROD)
   ) u_rt_sel (
      .src_addr   (d_rt_addr),
      .src_tuse   (d_rt_tuse),
      .src_grf    (d_rt_grf),
      .p_addr     (p_addr),
      .p_tnew     (p_tnew),
      .p_data     (p_data),
      .p_valid    (p_valid),
      .fwd_data   (d_rt_fwd),
      .data_stall (rt_stall)
   );

   assign mdu_busy = (mdu_cnt_q != '0);

   // Combine the stall sources; flush is active on the request cycle and the cycle after.
   always_comb begin
      mdu_stall  = d_is_mdu && (mdu_busy || mdu_start);
      eret_stall = d_is_eret && ex_mtc0_epc && p_valid[0];
      raw_stall  = rs_stall || rt_stall || mdu_stall || eret_stall;
      flush      = exc_req || (state_q == FLUSH);
   end

   // Exception sequencer: every request cycle leads to one flush cycle; back-to-back
   // requests keep it in FLUSH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = exc_req ? FLUSH : IDLE;
         FLUSH:   state_d = exc_req ? FLUSH : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // MDU busy countdown: a start (even while busy) reloads the latency, otherwise count down to zero.
   always_comb begin
      mdu_cnt_d = mdu_cnt_q;
      if (mdu_start) begin
         mdu_cnt_d = mdu_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (mdu_cnt_q != '0) begin
         mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
      end
   end

   // Stall counter counts only stalls that actually hold the pipeline, saturating at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (raw_stall && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;

   // Pipeline control: reset clears everything, flush clears all but the last register
   // and overrides stalls, a stall freezes PC and IF/ID and bubbles ID/EX.
   always_comb begin
      stall     = 1'b0;
      en_pc     = 1'b1;
      en_stage  = '1;
      clr_stage = '0;
      if (!reset_n) begin
         clr_stage = '1;
      end else if (flush) begin
         clr_stage = {1'b0, {NUM_PROD{1'b1}}};
      end else if (raw_stall) begin
         stall               = 1'b1;
         en_pc               = 1'b0;
         en_stage[REG_IFID]  = 1'b0;
         clr_stage[REG_IDEX] = 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         mdu_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mdu_cnt_q   <= mdu_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_unit_param.sv
// Testbench for hazard_unit_param: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the forwarding/stall/flush rules.
module tb_hazard_unit_param;

   localparam int XLEN    = 32;
   localparam int RA_W    = 5;
   localparam int T_W     = 2;
   localparam int NP      = 3;
   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic [RA_W-1:0]      d_rs_addr, d_rt_addr;
   logic [T_W-1:0]       d_rs_tuse, d_rt_tuse;
   logic [XLEN-1:0]      d_rs_grf, d_rt_grf;
   logic                 d_is_mdu, d_is_eret;
   logic [NP*RA_W-1:0]   p_addr;
   logic [NP*T_W-1:0]    p_tnew;
   logic [NP*XLEN-1:0]   p_data;
   logic [NP-1:0]        p_valid;
   logic                 ex_mtc0_epc, mdu_start, mdu_is_div, exc_req;
   logic [XLEN-1:0]      d_rs_fwd, d_rt_fwd;
   logic                 stall, en_pc, mdu_busy;
   logic [NP:0]          en_stage, clr_stage;
   logic [31:0]          stall_cnt;

   int                   check_cnt = 0;
   int                   pass_cnt  = 0;

   // Behavioural model state
   int                   m_mdu_left;
   bit                   m_in_flush;
   longint unsigned      m_stall_cnt;

   hazard_unit_param #(
      .XLEN(XLEN), .RA_W(RA_W), .T_W(T_W), .NUM_PROD(NP),
      .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
      .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
      .d_rs_grf(d_rs_grf), .d_rt_grf(d_rt_grf),
      .d_is_mdu(d_is_mdu), .d_is_eret(d_is_eret),
      .p_addr(p_addr), .p_tnew(p_tnew), .p_data(p_data), .p_valid(p_valid),
      .ex_mtc0_epc(ex_mtc0_epc), .mdu_start(mdu_start), .mdu_is_div(mdu_is_div),
      .exc_req(exc_req),
      .d_rs_fwd(d_rs_fwd), .d_rt_fwd(d_rt_fwd), .stall(stall), .en_pc(en_pc),
      .en_stage(en_stage), .clr_stage(clr_stage), .mdu_busy(mdu_busy),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference: the nearest valid producer writing the source decides; ready -> its data, else GRF.
   function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] src, input logic [XLEN-1:0] grf);
      for (int i = 0; i < NP; i++) begin
         if (p_valid[i] && src != 0 && p_addr[i*RA_W +: RA_W] == src)
            return (p_tnew[i*T_W +: T_W] == 0) ? p_data[i*XLEN +: XLEN] : grf;
      end
      return grf;
   endfunction

   // Reference: any valid producer writing the source whose result comes after the use.
   function automatic bit ref_data_stall(input logic [RA_W-1:0] src, input logic [T_W-1:0] tuse);
      if (tuse == 3) return 0;
      for (int i = 0; i < NP; i++) begin
         if (p_valid[i] && src != 0 && p_addr[i*RA_W +: RA_W] == src && tuse < p_tnew[i*T_W +: T_W])
            return 1;
      end
      return 0;
   endfunction

   function automatic bit ref_raw_stall();
      return ref_data_stall(d_rs_addr, d_rs_tuse) || ref_data_stall(d_rt_addr, d_rt_tuse)
          || (d_is_mdu && (m_mdu_left > 0 || mdu_start))
          || (d_is_eret && ex_mtc0_epc && p_valid[0]);
   endfunction

   function automatic bit ref_flush();
      return exc_req || m_in_flush;
   endfunction

   task automatic clear_inputs();
      d_rs_addr = 0; d_rt_addr = 0; d_rs_tuse = 2'b11; d_rt_tuse = 2'b11;
      d_rs_grf = 0; d_rt_grf = 0; d_is_mdu = 0; d_is_eret = 0;
      p_addr = 0; p_tnew = 0; p_data = 0; p_valid = 0;
      ex_mtc0_epc = 0; mdu_start = 0; mdu_is_div = 0; exc_req = 0;
   endtask

   task automatic set_prod(input int i, input logic [RA_W-1:0] a, input logic [T_W-1:0] t,
                           input logic [XLEN-1:0] d, input logic v);
      p_addr[i*RA_W +: RA_W] = a;
      p_tnew[i*T_W +: T_W]   = t;
      p_data[i*XLEN +: XLEN] = d;
      p_valid[i]             = v;
   endtask

   // Advance one clock, updating the model from the inputs present at the edge.
   task automatic tick();
      bit fl, rs;
      fl = ref_flush();
      rs = ref_raw_stall();
      if (rs && !fl && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if (mdu_start) m_mdu_left = mdu_is_div ? DIV_LAT : MUL_LAT;
      else if (m_mdu_left > 0) m_mdu_left--;
      m_in_flush = exc_req;
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      m_mdu_left = 0; m_in_flush = 0; m_stall_cnt = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      set_prod(0, 5'd8, 2'd2, 32'h0, 1'b1);
      d_rs_addr = 5'd8; d_rs_tuse = 2'd1;
      reset_n = 1'b0;
      #2;
      check_cnt++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall got %b want 0", stall); else pass_cnt++;
      check_cnt++; if (clr_stage !== 4'hF) $display("[TB] FAIL reset_clr got %h want f", clr_stage); else pass_cnt++;
      check_cnt++; if (en_stage !== 4'hF || en_pc !== 1'b1) $display("[TB] FAIL reset_en got %h/%b want f/1", en_stage, en_pc); else pass_cnt++;
      check_cnt++; if (stall_cnt !== 32'd0 || mdu_busy !== 1'b0) $display("[TB] FAIL reset_cnt got %0d/%b want 0/0", stall_cnt, mdu_busy); else pass_cnt++;
      clear_inputs();
      release_reset();
      check_cnt++; if (clr_stage !== 4'h0 || stall !== 1'b0) $display("[TB] FAIL post_reset got clr %h stall %b want 0/0", clr_stage, stall); else pass_cnt++;
   endtask

   task automatic test_forward();
      clear_inputs();
      set_prod(0, 5'd8, 2'd0, 32'h1234, 1'b1);
      d_rs_addr = 5'd8; d_rs_tuse = 2'd0; d_rs_grf = 32'hDEAD_0000;
      #1;
      check_cnt++; if (d_rs_fwd !== 32'h1234) $display("[TB] FAIL fwd_ex got %h want 1234", d_rs_fwd); else pass_cnt++;
      check_cnt++; if (stall !== 1'b0) $display("[TB] FAIL fwd_nostall got %b want 0", stall); else pass_cnt++;
      d_rt_addr = 5'd0; d_rt_grf = 32'h5555; set_prod(1, 5'd0, 2'd0, 32'h7777, 1'b1);
      #1;
      check_cnt++; if (d_rt_fwd !== 32'h5555) $display("[TB] FAIL fwd_r0 got %h want 5555", d_rt_fwd); else pass_cnt++;
      tick();
   endtask

   task automatic test_data_stall();
      clear_inputs();
      set_prod(0, 5'd8, 2'd2, 32'h0, 1'b1);
      d_rs_addr = 5'd8; d_rs_tuse = 2'd1;
      #1;
      check_cnt++; if (stall !== 1'b1 || en_pc !== 1'b0) $display("[TB] FAIL dstall got %b/%b want 1/0", stall, en_pc); else pass_cnt++;
      check_cnt++; if (clr_stage !== 4'b0010 || en_stage !== 4'b1110) $display("[TB] FAIL dstall_ctl got clr %b en %b want 0010/1110", clr_stage, en_stage); else pass_cnt++;
      tick();
      set_prod(0, 5'd8, 2'd1, 32'h0, 1'b1);
      #1;
      check_cnt++; if (stall !== 1'b0) $display("[TB] FAIL dstall_release got %b want 0", stall); else pass_cnt++;
      d_rs_tuse = 2'b11; set_prod(0, 5'd8, 2'd3, 32'h0, 1'b1);
      #1;
      check_cnt++; if (stall !== 1'b0) $display("[TB] FAIL nouse got %b want 0", stall); else pass_cnt++;
      tick();
   endtask

   task automatic test_shadow();
      clear_inputs();
      set_prod(0, 5'd8, 2'd1, 32'hAAAA, 1'b1);
      set_prod(1, 5'd8, 2'd0, 32'hBBBB, 1'b1);
      d_rs_addr = 5'd8; d_rs_tuse = 2'd1; d_rs_grf = 32'hC0C0;
      #1;
      check_cnt++; if (d_rs_fwd !== 32'hC0C0 || stall !== 1'b0) $display("[TB] FAIL shadow got %h/%b want c0c0/0", d_rs_fwd, stall); else pass_cnt++;
      tick();
      set_prod(0, 5'd8, 2'd0, 32'hAAAB, 1'b1);
      #1;
      check_cnt++; if (d_rs_fwd !== 32'hAAAB) $display("[TB] FAIL shadow_ready got %h want aaab", d_rs_fwd); else pass_cnt++;
      set_prod(0, 5'd8, 2'd0, 32'hAAAB, 1'b0);
      #1;
      check_cnt++; if (d_rs_fwd !== 32'hBBBB) $display("[TB] FAIL older_stage got %h want bbbb", d_rs_fwd); else pass_cnt++;
      tick();
   endtask

   task automatic test_mdu_div();
      int n;
      int start_cnt;
      clear_inputs();
      start_cnt = int'(m_stall_cnt);
      mdu_start = 1'b1; mdu_is_div = 1'b1; d_is_mdu = 1'b1;
      #1;
      n = 0;
      while (stall === 1'b1 && n < 50) begin
         n++;
         tick();
         mdu_start = 1'b0;
         #1;
      end
      check_cnt++; if (n != DIV_LAT + 1) $display("[TB] FAIL div_stall_len got %0d want %0d", n, DIV_LAT + 1); else pass_cnt++;
      check_cnt++; if (stall_cnt !== 32'(start_cnt + DIV_LAT + 1)) $display("[TB] FAIL div_stall_cnt got %0d want %0d", stall_cnt, start_cnt + DIV_LAT + 1); else pass_cnt++;
      check_cnt++; if (mdu_busy !== 1'b0) $display("[TB] FAIL div_busy_end got %b want 0", mdu_busy); else pass_cnt++;
   endtask

   task automatic test_exc_flush();
      longint unsigned saved;
      clear_inputs();
      set_prod(0, 5'd8, 2'd2, 32'h0, 1'b1);
      d_rs_addr = 5'd8; d_rs_tuse = 2'd1;
      #1;
      tick();
      saved = m_stall_cnt;
      exc_req = 1'b1;
      #1;
      check_cnt++; if (clr_stage !== 4'b0111 || en_pc !== 1'b1 || en_stage !== 4'hF) $display("[TB] FAIL exc_cycle got clr %b en %b pc %b want 0111/1111/1", clr_stage, en_stage, en_pc); else pass_cnt++;
      tick();
      exc_req = 1'b0;
      #1;
      check_cnt++; if (clr_stage !== 4'b0111 || en_pc !== 1'b1 || en_stage !== 4'hF) $display("[TB] FAIL flush_cycle got clr %b en %b pc %b want 0111/1111/1", clr_stage, en_stage, en_pc); else pass_cnt++;
      tick();
      check_cnt++; if (stall_cnt !== 32'(saved)) $display("[TB] FAIL flush_cnt got %0d want %0d", stall_cnt, saved); else pass_cnt++;
      check_cnt++; if (stall !== 1'b1 || clr_stage !== 4'b0010) $display("[TB] FAIL after_flush got %b/%b want 1/0010", stall, clr_stage); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_div();
      clear_inputs();
      mdu_start = 1'b1; mdu_is_div = 1'b1; d_is_mdu = 1'b1;
      tick();
      mdu_start = 1'b0;
      tick(); tick();
      check_cnt++; if (mdu_busy !== 1'b1 || stall_cnt === 32'd0) $display("[TB] FAIL pre_reset got busy %b cnt %0d want 1/nonzero", mdu_busy, stall_cnt); else pass_cnt++;
      reset_n = 1'b0;
      #1;
      check_cnt++; if (mdu_busy !== 1'b0 || stall_cnt !== 32'd0) $display("[TB] FAIL mid_reset got busy %b cnt %0d want 0/0", mdu_busy, stall_cnt); else pass_cnt++;
      @(posedge clk); #1;
      check_cnt++; if (clr_stage !== 4'hF || stall !== 1'b0 || en_stage !== 4'hF) $display("[TB] FAIL held_reset got clr %h stall %b en %h want f/0/f", clr_stage, stall, en_stage); else pass_cnt++;
      release_reset();
      check_cnt++; if (mdu_busy !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL after_reset got busy %b stall %b want 0/0", mdu_busy, stall); else pass_cnt++;
   endtask

   task automatic test_random();
      bit fl, rs;
      logic [3:0] exp_en, exp_clr;
      logic       exp_pc;
      clear_inputs();
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NP; i++)
            set_prod(i, 5'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), $urandom, 1'($urandom_range(1, 0)));
         d_rs_addr = 5'($urandom_range(3, 0)); d_rt_addr = 5'($urandom_range(3, 0));
         d_rs_tuse = 2'($urandom_range(3, 0)); d_rt_tuse = 2'($urandom_range(3, 0));
         d_rs_grf = $urandom; d_rt_grf = $urandom;
         d_is_mdu = ($urandom_range(3, 0) == 0);
         mdu_start = ($urandom_range(7, 0) == 0); mdu_is_div = 1'($urandom_range(1, 0));
         exc_req = ($urandom_range(15, 0) == 0);
         d_is_eret = ($urandom_range(7, 0) == 0); ex_mtc0_epc = 1'($urandom_range(1, 0));
         #1;
         fl = ref_flush(); rs = ref_raw_stall();
         if (fl) begin exp_pc = 1; exp_en = 4'hF; exp_clr = 4'b0111; end
         else if (rs) begin exp_pc = 0; exp_en = 4'b1110; exp_clr = 4'b0010; end
         else begin exp_pc = 1; exp_en = 4'hF; exp_clr = 4'h0; end
         check_cnt++; if (d_rs_fwd !== ref_fwd(d_rs_addr, d_rs_grf)) $display("[TB] FAIL rnd_rs c%0d got %h want %h", c, d_rs_fwd, ref_fwd(d_rs_addr, d_rs_grf)); else pass_cnt++;
         check_cnt++; if (d_rt_fwd !== ref_fwd(d_rt_addr, d_rt_grf)) $display("[TB] FAIL rnd_rt c%0d got %h want %h", c, d_rt_fwd, ref_fwd(d_rt_addr, d_rt_grf)); else pass_cnt++;
         check_cnt++; if (en_pc !== exp_pc || en_stage !== exp_en || clr_stage !== exp_clr) $display("[TB] FAIL rnd_ctl c%0d got pc %b en %b clr %b want %b/%b/%b", c, en_pc, en_stage, clr_stage, exp_pc, exp_en, exp_clr); else pass_cnt++;
         if (!fl) begin
            check_cnt++; if (stall !== rs) $display("[TB] FAIL rnd_stall c%0d got %b want %b", c, stall, rs); else pass_cnt++;
         end
         check_cnt++; if (mdu_busy !== (m_mdu_left != 0)) $display("[TB] FAIL rnd_busy c%0d got %b want %b", c, mdu_busy, m_mdu_left != 0); else pass_cnt++;
         check_cnt++; if (stall_cnt !== 32'(m_stall_cnt)) $display("[TB] FAIL rnd_cnt c%0d got %0d want %0d", c, stall_cnt, m_stall_cnt); else pass_cnt++;
         tick();
      end
   endtask

   // Run all scenarios in order, then report.
   initial begin
      m_mdu_left = 0; m_in_flush = 0; m_stall_cnt = 0;
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_forward();
      test_data_stall();
      test_shadow();
      test_mdu_div();
      test_exc_flush();
      test_reset_mid_div();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
